akuma_sprite_fetch: RTL

- Upstream feeder of the Akuma colour palette lookup.
- Each cycle it takes the current VGA draw coordinate and the sprite's screen position, and computes the sprite ROM address. It runs a per-frame animation counter and pipelines the external synchronous ROM read.
- It delivers a 4-bit palette index, aligned with in-sprite and opaque flags, for the palette and the colour mapper to consume.

---
 rtl/akuma_sprite_fetch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/akuma_sprite_fetch.sv
// Sprite ROM address generator, per-frame animation counter and 3-cycle fetch pipeline.
// Optional horizontal mirroring via facing_right when AKUMA_MIRROR_EN is defined.
module akuma_sprite_fetch #(
    parameter int unsigned SPRITE_W   = 64,
    parameter int unsigned SPRITE_H   = 96,
    parameter int unsigned NUM_FRAMES = 4,
    parameter int unsigned FRAME_HOLD = 8,
    parameter int unsigned ADDR_W     = 15
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          frame_tick,
    input  logic                          anim_restart,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic [9:0]                    pos_x,
    input  logic [9:0]                    pos_y,
`ifdef AKUMA_MIRROR_EN
    input  logic                          facing_right,
`endif
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [3:0]                    rom_data,
    output logic [3:0]                    pixel_index,
    output logic                          pixel_in_sprite,
    output logic                          pixel_opaque,
    output logic [$clog2(NUM_FRAMES)-1:0] anim_frame
);

    localparam int unsigned COL_W      = $clog2(SPRITE_W);
    localparam int unsigned FRM_W      = $clog2(NUM_FRAMES);
    localparam int unsigned HOLD_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int unsigned FRAME_SIZE = SPRITE_W * SPRITE_H;

    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              in_box_d1_q, in_box_d2_q;
    logic [3:0]        pix_idx_q, pix_idx_d;
    logic              pix_in_q, pix_op_q, pix_op_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [FRM_W-1:0]  frame_q, frame_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic [10:0]       x_end_c, y_end_c;
    logic              in_box_c;
    logic [9:0]        row_c;
    logic [COL_W-1:0]  col_c, col_eff_c;
    logic [ADDR_W-1:0] addr_ofs_c;

    // Stage 0: box test on 11-bit sums so a sprite past column/row 1023 clips
    assign x_end_c  = {1'b0, pos_x} + 11'(SPRITE_W);
    assign y_end_c  = {1'b0, pos_y} + 11'(SPRITE_H);
    assign in_box_c = (DrawX >= pos_x) && ({1'b0, DrawX} < x_end_c) &&
                      (DrawY >= pos_y) && ({1'b0, DrawY} < y_end_c);
    assign row_c    = DrawY - pos_y;
    assign col_c    = COL_W'(DrawX - pos_x);

`ifdef AKUMA_MIRROR_EN
    // SPRITE_W is a power of two, so SPRITE_W-1-col is the bitwise inverse
    assign col_eff_c = facing_right ? ~col_c : col_c;
`else
    assign col_eff_c = col_c;
`endif

    assign addr_ofs_c = (ADDR_W'(row_c) << COL_W) | ADDR_W'(col_eff_c);

    always_comb begin
        rom_addr_d = base_q;
        if (in_box_c) begin
            rom_addr_d = base_q + addr_ofs_c;
        end
        pix_idx_d = in_box_d2_q ? rom_data : 4'd0;
        pix_op_d  = in_box_d2_q && (rom_data != 4'd0) && (rom_data < 4'd14);
    end

    // Animation counters; restart beats a coincident tick
    always_comb begin
        hold_d  = hold_q;
        frame_d = frame_q;
        base_d  = base_q;
        if (anim_restart) begin
            hold_d  = '0;
            frame_d = '0;
            base_d  = '0;
        end else if (frame_tick) begin
            if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
                hold_d = '0;
                if (frame_q == FRM_W'(NUM_FRAMES - 1)) begin
                    frame_d = '0;
                    base_d  = '0;
                end else begin
                    frame_d = frame_q + FRM_W'(1);
                    base_d  = base_q + ADDR_W'(FRAME_SIZE);
                end
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_q  <= '0;
            in_box_d1_q <= 1'b0;
            in_box_d2_q <= 1'b0;
            pix_idx_q   <= '0;
            pix_in_q    <= 1'b0;
            pix_op_q    <= 1'b0;
            hold_q      <= '0;
            frame_q     <= '0;
            base_q      <= '0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            in_box_d1_q <= in_box_c;
            in_box_d2_q <= in_box_d1_q;
            pix_idx_q   <= pix_idx_d;
            pix_in_q    <= in_box_d2_q;
            pix_op_q    <= pix_op_d;
            hold_q      <= hold_d;
            frame_q     <= frame_d;
            base_q      <= base_d;
        end
    end

    assign rom_addr        = rom_addr_q;
    assign pixel_index     = pix_idx_q;
    assign pixel_in_sprite = pix_in_q;
    assign pixel_opaque    = pix_op_q;
    assign anim_frame      = frame_q;

endmodule
